p405s_icu_tag_bist_ctrl: RTL and testbench

//  March C- BIST engine for the ICU 256x46 tag SRAM. Drives the SRAM wrapper's

---
 rtl/p405s_icu_tag_bist_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_p405s_icu_tag_bist_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/p405s_icu_tag_bist_ctrl.sv
// March C- BIST engine for the ICU 256x46 tag SRAM: drives the wrapper BIST port and checks reads.
// Define P405S_ICU_BIST_CKBD_EN for a per-address checkerboard background instead of solid zero.
module p405s_icu_tag_bist_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 46,
  parameter int DEPTH  = 256
) (
  input  logic              cclk,
  input  logic              reset,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_W-1:0] bist_fail_addr,
  output logic [7:0]        bist_err_cnt,
  output logic              bist_mode,
  output logic              bist_ce_n,
  output logic              bist_we_n,
  output logic [ADDR_W-1:0] bist_addr,
  output logic [DATA_W-1:0] bist_wr_data,
  input  logic [DATA_W-1:0] bist_rd_data
);

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN} state_e;

`ifdef P405S_ICU_BIST_CKBD_EN
  localparam bit CKBD = 1'b1;
`else
  localparam bit CKBD = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  function automatic logic [DATA_W-1:0] bg(input logic odd);
    if (!CKBD)    bg = '0;
    else if (odd) bg = DATA_W'(46'h1555_5555_5555);
    else          bg = DATA_W'(46'h2AAA_AAAA_AAAA);
  endfunction

  state_e            state_q, state_d;
  logic              arm_q, arm_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              ce_n_q, ce_n_d, we_n_q, we_n_d;
  logic              busy_q, busy_d, mode_q, mode_d;
  logic              done_q, done_d, fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              chk_q, chk_d, chk_inv_q, chk_inv_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;

  logic [ADDR_W-1:0] addr_inc, addr_dec;
  logic [DATA_W-1:0] exp_data;
  logic              up_elem, inv_wr;

  assign addr_inc = addr_q + 1'b1;
  assign addr_dec = addr_q - 1'b1;
  assign up_elem  = (state_q == M1) || (state_q == M2);
  assign inv_wr   = (state_q == M1) || (state_q == M3);

  // Every read is checked in the following cycle, when its data comes back.
  assign exp_data = chk_inv_q ? ~bg(chk_addr_q[0]) : bg(chk_addr_q[0]);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    arm_d       = 1'b0;
    phase_d     = phase_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    ce_n_d      = 1'b1;
    we_n_d      = 1'b1;
    busy_d      = busy_q;
    mode_d      = mode_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    err_cnt_d   = err_cnt_q;
    chk_d       = ~ce_n_q & we_n_q;
    chk_addr_d  = addr_q;
    chk_inv_d   = (state_q == M2) || (state_q == M4);

    if (chk_q && (bist_rd_data != exp_data)) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = chk_addr_q;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (arm_q) begin
          state_d   = M0;
          busy_d    = 1'b1;
          mode_d    = 1'b1;
          addr_d    = '0;
          ce_n_d    = 1'b0;
          we_n_d    = 1'b0;
          wr_data_d = bg(1'b0);
        end else if (bist_start) begin
          arm_d       = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          err_cnt_d   = '0;
        end
      end
      M0: begin
        ce_n_d = 1'b0;
        if (addr_q == ADDR_LAST) begin
          state_d = M1;
          addr_d  = '0;
          phase_d = 1'b0;
        end else begin
          we_n_d    = 1'b0;
          addr_d    = addr_inc;
          wr_data_d = bg(addr_inc[0]);
        end
      end
      M1, M2, M3, M4: begin
        ce_n_d = 1'b0;
        if (!phase_q) begin
          phase_d   = 1'b1;
          we_n_d    = 1'b0;
          wr_data_d = inv_wr ? ~bg(addr_q[0]) : bg(addr_q[0]);
        end else begin
          phase_d = 1'b0;
          if (up_elem) begin
            if (addr_q == ADDR_LAST) begin
              state_d = (state_q == M1) ? M2 : M3;
              addr_d  = (state_q == M1) ? '0 : ADDR_LAST;
            end else begin
              addr_d = addr_inc;
            end
          end else begin
            if (addr_q == '0) begin
              state_d = (state_q == M3) ? M4 : M5;
              addr_d  = ADDR_LAST;
            end else begin
              addr_d = addr_dec;
            end
          end
        end
      end
      M5: begin
        if (addr_q == '0) begin
          state_d = DRAIN;
        end else begin
          ce_n_d = 1'b0;
          addr_d = addr_dec;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        mode_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge cclk) begin
    if (reset) begin
      state_q     <= IDLE;
      arm_q       <= 1'b0;
      phase_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      err_cnt_q   <= '0;
      chk_q       <= 1'b0;
      chk_inv_q   <= 1'b0;
      chk_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      err_cnt_q   <= err_cnt_d;
      chk_q       <= chk_d;
      chk_inv_q   <= chk_inv_d;
      chk_addr_q  <= chk_addr_d;
    end
  end

  assign bist_busy      = busy_q;
  assign bist_done      = done_q;
  assign bist_fail      = fail_q;
  assign bist_fail_addr = fail_addr_q;
  assign bist_err_cnt   = err_cnt_q;
  assign bist_mode      = mode_q;
  assign bist_ce_n      = ce_n_q;
  assign bist_we_n      = we_n_q;
  assign bist_addr      = addr_q;
  assign bist_wr_data   = wr_data_q;

endmodule

// File: tb/tb_p405s_icu_tag_bist_ctrl.sv
// Bench for p405s_icu_tag_bist_ctrl: fault-injecting SRAM model, cycle-exact access trace
// and an algorithmic March C- reference for pass/fail, first failing address and error count.
module tb_p405s_icu_tag_bist_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 46;
  localparam int DEPTH  = 256;
  localparam int RUN_CYCLES = 2561;

  logic              cclk = 1'b0;
  logic              reset;
  logic              bist_start;
  logic              bist_busy, bist_done, bist_fail, bist_mode, bist_ce_n, bist_we_n;
  logic [ADDR_W-1:0] bist_fail_addr, bist_addr;
  logic [7:0]        bist_err_cnt;
  logic [DATA_W-1:0] bist_wr_data;
  logic [DATA_W-1:0] bist_rd_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sa1 [DEPTH];
  logic [DATA_W-1:0] sa0 [DEPTH];
  bit                force_ones = 1'b0;
  logic [DATA_W-1:0] first_wr0, first_wr1;

  p405s_icu_tag_bist_ctrl dut (
    .cclk(cclk), .reset(reset), .bist_start(bist_start),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
    .bist_fail_addr(bist_fail_addr), .bist_err_cnt(bist_err_cnt),
    .bist_mode(bist_mode), .bist_ce_n(bist_ce_n), .bist_we_n(bist_we_n),
    .bist_addr(bist_addr), .bist_wr_data(bist_wr_data), .bist_rd_data(bist_rd_data)
  );

  always #5 cclk = ~cclk;

  function automatic logic [DATA_W-1:0] bg(input int a);
`ifdef P405S_ICU_BIST_CKBD_EN
    return a[0] ? 46'h1555_5555_5555 : 46'h2AAA_AAAA_AAAA;
`else
    return '0;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] store_val(input int a, input logic [DATA_W-1:0] w);
    return (w | sa1[a]) & ~sa0[a];
  endfunction

  // SRAM with stuck-at cells; read data appears the cycle after the read.
  always @(posedge cclk) begin
    if (bist_mode && !bist_ce_n) begin
      if (!bist_we_n) mem[bist_addr] <= store_val(int'(bist_addr), bist_wr_data);
      else            bist_rd_data   <= force_ones ? '1 : mem[bist_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      sa1[a] = '0;
      sa0[a] = '0;
    end
  endtask

  // March C- evaluated directly on an array: M1..M5 as read/expect/write-complement passes.
  task automatic ref_march(output int errs, output logic [7:0] faddr, output bit failed);
    logic [DATA_W-1:0] m [DEPTH];
    logic [DATA_W-1:0] exp_v, got;
    int a;
    errs = 0; faddr = '0; failed = 1'b0;
    for (int i = 0; i < DEPTH; i++) m[i] = store_val(i, bg(i));
    for (int e = 1; e <= 5; e++) begin
      for (int i = 0; i < DEPTH; i++) begin
        a     = (e <= 2) ? i : DEPTH - 1 - i;
        exp_v = (e == 2 || e == 4) ? ~bg(a) : bg(a);
        got   = force_ones ? '1 : m[a];
        if (got !== exp_v) begin
          if (!failed) faddr = 8'(a);
          failed = 1'b1;
          if (errs < 255) errs++;
        end
        if (e < 5) m[a] = store_val(a, ~exp_v);
      end
    end
  endtask

  // Expected SRAM access in cycle k (cycle k begins at edge k after the start-sample edge 0).
  task automatic exp_access(input int k, output logic ce_n, output logic we_n,
                            output logic [7:0] a, output logic [DATA_W-1:0] d);
    int j, e, i;
    ce_n = 1'b1; we_n = 1'b1; a = '0; d = '0;
    if (k <= 256) begin
      ce_n = 1'b0; we_n = 1'b0; a = 8'(k - 1); d = bg(k - 1);
    end else if (k <= 2304) begin
      j = k - 257; e = j / 512; i = (j % 512) / 2;
      a = 8'((e < 2) ? i : 255 - i);
      ce_n = 1'b0;
      if (j % 2 == 1) begin
        we_n = 1'b0;
        d = (e % 2 == 0) ? ~bg(int'(a)) : bg(int'(a));
      end
    end else if (k <= 2560) begin
      ce_n = 1'b0; a = 8'(2560 - k);
    end
  endtask

  task automatic reset_checks(input string name);
    check({name, ".busy"},    64'(bist_busy), 64'd0);
    check({name, ".mode"},    64'(bist_mode), 64'd0);
    check({name, ".ce_n"},    64'(bist_ce_n), 64'd1);
    check({name, ".we_n"},    64'(bist_we_n), 64'd1);
    check({name, ".done"},    64'(bist_done), 64'd0);
    check({name, ".fail"},    64'(bist_fail), 64'd0);
    check({name, ".err_cnt"}, 64'(bist_err_cnt), 64'd0);
    check({name, ".addr"},    64'(bist_addr), 64'd0);
    check({name, ".wr_data"}, 64'(bist_wr_data), 64'd0);
  endtask

  task automatic run_march(input string name, input bit pulses, input int reset_at);
    int          ref_errs, trace_err;
    logic [7:0]  ref_faddr, ea;
    bit          ref_failed, aborted;
    logic        ece_n, ewe_n;
    logic [DATA_W-1:0] ed;
    string       first_diff;
    ref_march(ref_errs, ref_faddr, ref_failed);
    trace_err = 0; aborted = 1'b0; first_diff = "";
    @(negedge cclk) bist_start = 1'b1;
    @(negedge cclk) bist_start = 1'b0;
    check({name, ".arm_busy"}, 64'(bist_busy), 64'd0);
    check({name, ".arm_done_clr"}, 64'(bist_done), 64'd0);
    check({name, ".arm_err_clr"}, 64'(bist_err_cnt), 64'd0);
    for (int k = 1; k <= RUN_CYCLES; k++) begin
      @(negedge cclk);
      bist_start = pulses && (k == 100 || k == 2000);
      if (k == 1) first_wr0 = bist_wr_data;
      if (k == 2) first_wr1 = bist_wr_data;
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge cclk) reset = 1'b0;
        reset_checks({name, ".midrun_reset"});
        aborted = 1'b1;
        break;
      end
      exp_access(k, ece_n, ewe_n, ea, ed);
      if (bist_busy !== 1'b1 || bist_mode !== 1'b1 || bist_ce_n !== ece_n || bist_we_n !== ewe_n ||
          (!ece_n && bist_addr !== ea) || (!ece_n && !ewe_n && bist_wr_data !== ed)) begin
        if (trace_err == 0)
          first_diff = $sformatf("cycle %0d busy=%b ce_n=%b we_n=%b addr=%0h wd=%0h want ce_n=%b we_n=%b addr=%0h wd=%0h",
                                 k, bist_busy, bist_ce_n, bist_we_n, bist_addr, bist_wr_data, ece_n, ewe_n, ea, ed);
        trace_err++;
      end
    end
    bist_start = 1'b0;
    if (!aborted) begin
      check({name, ".trace_diffs"}, 64'(trace_err), 64'd0);
      if (trace_err != 0) $display("  %s first trace difference: %s", name, first_diff);
      @(negedge cclk);
      check({name, ".done"},      64'(bist_done), 64'd1);
      check({name, ".busy_end"},  64'(bist_busy), 64'd0);
      check({name, ".mode_end"},  64'(bist_mode), 64'd0);
      check({name, ".ce_n_end"},  64'(bist_ce_n), 64'd1);
      check({name, ".fail"},      64'(bist_fail), 64'(ref_failed));
      check({name, ".fail_addr"}, 64'(bist_fail_addr), 64'(ref_faddr));
      check({name, ".err_cnt"},   64'(bist_err_cnt), 64'(ref_errs));
      repeat (5) @(negedge cclk);
      check({name, ".done_sticky"}, 64'(bist_done), 64'd1);
      check({name, ".fail_sticky"}, 64'(bist_fail), 64'(ref_failed));
    end
  endtask

  initial begin
    int n_f, fa, fb;
    reset = 1'b1;
    bist_start = 1'b0;
    clear_faults();
    repeat (3) @(negedge cclk);
    reset_checks("por");
    reset = 1'b0;
    repeat (2) @(negedge cclk);

    run_march("clean", 1'b0, 0);
`ifdef P405S_ICU_BIST_CKBD_EN
    check("clean.m0_wr_addr0", 64'(first_wr0), 64'h2AAA_AAAA_AAAA);
    check("clean.m0_wr_addr1", 64'(first_wr1), 64'h1555_5555_5555);
`else
    check("clean.m0_wr_addr0", 64'(first_wr0), 64'h0);
    check("clean.m0_wr_addr1", 64'(first_wr1), 64'h0);
`endif

    sa1[8'h10][5] = 1'b1;
    run_march("sa1_bit5_a10", 1'b0, 0);
`ifdef P405S_ICU_BIST_CKBD_EN
    check("sa1_bit5_a10.err_const", 64'(bist_err_cnt), 64'd2);
`else
    check("sa1_bit5_a10.err_const", 64'(bist_err_cnt), 64'd3);
`endif
    check("sa1_bit5_a10.faddr_const", 64'(bist_fail_addr), 64'h10);
    clear_faults();

    run_march("ignored_starts", 1'b1, 0);

    run_march("reset_1500", 1'b0, 1500);
    repeat (2) @(negedge cclk);
    run_march("after_reset", 1'b0, 0);

    force_ones = 1'b1;
    run_march("rd_ones", 1'b0, 0);
    check("rd_ones.err_sat", 64'(bist_err_cnt), 64'hFF);
    check("rd_ones.faddr0",  64'(bist_fail_addr), 64'h00);
    force_ones = 1'b0;

    for (int r = 0; r < 3; r++) begin
      clear_faults();
      n_f = $urandom_range(1, 4);
      for (int f = 0; f < n_f; f++) begin
        fa = $urandom_range(0, DEPTH - 1);
        fb = $urandom_range(0, DATA_W - 1);
        if ($urandom_range(0, 1) == 1) sa1[fa][fb] = 1'b1;
        else                           sa0[fa][fb] = 1'b1;
      end
      run_march($sformatf("rand%0d", r), 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
